led_breath_sched: RTL
=====================

Name: led_breath_sched

Overview:
- Multi-channel LED breathing scheduler for the Nexys4 LED bank.
- Owns one shared PWM period counter and one duty envelope, and sequences a breathing cycle (ramp up, hold on, ramp down, hold off) onto LED channels.
- Three channel modes: single selected channel, chase (advance one channel per breath), or all channels in unison.
- Sits between the board switch/button logic and the LED pins.

Parameters:
- NUM_CH, 8, number of LED channels driven (2..16).
- PERIOD, 50000, PWM period in clk_100M cycles.
- STEP, 500, duty increment/decrement applied once per PWM period.
- HOLD_PERIODS, 20, PWM periods spent in each hold state (>=1).
- CNT_W, 16, width of pwm_cnt/duty; must represent PERIOD.

Ports:
- clk_100M  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  run request, level.
- mode  in  2  0 = single, 1 = chase, 2 = all, 3 = treated as single.
- ch_sel  in  4  channel for single mode; a value >= NUM_CH selects channel 0.
- led_out  out  NUM_CH  PWM outputs, active-high (1 = LED lit).
- active_ch  out  4  channel currently breathing (0 in all mode).
- busy  out  1  high whenever state != IDLE.
- cycle_done  out  1  one-clock pulse at the end of each full breath.

Behaviour:
- One clock (clk_100M); reset is synchronous, active-high, sampled on the rising edge.
- Reset values: state = IDLE, pwm_cnt = 0, duty = 0, hold_cnt = 0, led_out = 0, active_ch = 0, busy = 0, cycle_done = 0.
- States: IDLE, UP, HOLD_ON, DOWN, HOLD_OFF.
- IDLE:
  - pwm_cnt and duty are held at 0; led_out = 0.
  - If en = 1, latch mode and the resolved channel, then go to UP next clock with pwm_cnt = 0.
- PWM counter (non-IDLE states):
  - pwm_cnt runs 0..PERIOD-1 and wraps to 0.
  - period_tick = (pwm_cnt == PERIOD-1).
  - All envelope updates happen only on period_tick.
- UP, on tick:
  - If duty + STEP >= PERIOD: duty = PERIOD, hold_cnt = 0, go to HOLD_ON.
  - Else duty += STEP.
  - Compute the sum at CNT_W+1 bits; no overflow.
- HOLD_ON, on tick: hold_cnt++; when hold_cnt == HOLD_PERIODS-1, clear hold_cnt and go to DOWN.
- DOWN, on tick:
  - If duty <= STEP: duty = 0, go to HOLD_OFF.
  - Else duty -= STEP.
  - duty never underflows.
- HOLD_OFF, on the final tick (same count rule as HOLD_ON):
  - Register cycle_done = 1 for exactly the next clock.
  - Channel advance:
    - chase: active_ch = (active_ch + 1) mod NUM_CH.
    - single: re-sample ch_sel.
    - all: active_ch stays 0.
  - Re-sample mode; if the mode changed, active_ch = 0 for chase, the resolved ch_sel for single, 0 for all.
  - If en = 1 go to UP, else go to IDLE.
- Stop semantics:
  - en is sampled only in IDLE and at the end of HOLD_OFF.
  - Dropping en mid-breath finishes the current breath; the block never truncates a breath.
- mode and ch_sel changes mid-breath are ignored until the next HOLD_OFF end.
- led_out:
  - Lit condition: (pwm_cnt < duty) registered, so there is one clock of latency from pwm_cnt.
  - single/chase: only bit active_ch follows the lit condition; all other bits are 0.
  - all: every bit follows the lit condition.
  - duty = PERIOD gives constant on; duty = 0 gives constant off.
- Breath length: ceil(PERIOD/STEP) ticks up + HOLD_PERIODS + ceil(PERIOD/STEP) ticks down + HOLD_PERIODS, in PWM periods.
- Reset mid-operation: every register returns to its reset value on the next edge and led_out = 0 the clock after rst is sampled; no partial pulse of cycle_done.

Test Plan (PERIOD = 10, STEP = 3, HOLD_PERIODS = 2, NUM_CH = 4):
- Ramp: en = 1, mode = 0, ch_sel = 2 from reset.
  - duty sequence after each tick: 3, 6, 9, 10, 10, 10, 7, 4, 1, 0, 0, 0.
  - led_out[2] high for duty clocks per period; the other bits stay 0.
  - cycle_done high exactly at clock 120 after UP entry.
- Chase: mode = 1, en held high for 5 breaths.
  - active_ch = 0, 1, 2, 3, 0.
  - 5 cycle_done pulses spaced 120 clocks apart.
- Graceful stop: en = 0 during DOWN of breath 1.
  - The breath completes and cycle_done pulses once.
  - busy falls on the following clock; led_out = 0 from then on.
- All mode with ch_sel = 9 and mode = 3: all mode drives led_out = 4'hF while lit; mode 3 with ch_sel = 9 selects channel 0 only.
- Mid-breath reset: assert rst in HOLD_ON.
  - Next clock: duty = 0, led_out = 0, busy = 0, cycle_done stays 0.
  - Release rst with en = 1: restarts at UP with duty 3 after the first tick.
- Mode change mid-breath: switch 0 to 2 during UP.
  - Takes effect only after the HOLD_OFF end.
  - Before then only the single channel is lit.

Source files
------------

// File: rtl/led_breath_sched.sv
// Multi-channel LED breathing scheduler: one shared PWM period counter and duty
// envelope (ramp up, hold on, ramp down, hold off) mapped onto LED channels.
module led_breath_sched #(
    parameter int unsigned NUM_CH       = 8,
    parameter int unsigned PERIOD       = 50000,
    parameter int unsigned STEP         = 500,
    parameter int unsigned HOLD_PERIODS = 20,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [3:0]        ch_sel,
    output logic [NUM_CH-1:0] led_out,
    output logic [3:0]        active_ch,
    output logic              busy,
    output logic              cycle_done
);

    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [CNT_W-1:0]  PERIOD_V  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]  PERIOD_M1 = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  STEP_V    = CNT_W'(STEP);
    localparam logic [SUM_W-1:0]  PERIOD_X  = SUM_W'(PERIOD);
    localparam logic [SUM_W-1:0]  STEP_X    = SUM_W'(STEP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
    localparam logic [3:0]        CH_LAST   = 4'(NUM_CH - 1);
    localparam logic [4:0]        CH_LIMIT  = 5'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_HOLD_ON,
        S_DOWN,
        S_HOLD_OFF
    } state_t;

    typedef enum logic [1:0] {
        M_SINGLE = 2'd0,
        M_CHASE  = 2'd1,
        M_ALL    = 2'd2
    } mode_t;

    state_t              state, state_d;
    mode_t               cur_mode, mode_d, mode_norm;
    logic [CNT_W-1:0]    pwm_cnt, pwm_cnt_d;
    logic [CNT_W-1:0]    duty, duty_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [3:0]          ch_d, ch_res;
    logic [NUM_CH-1:0]   led_d;
    logic                busy_d, done_d;
    logic                period_tick, lit;
    logic [SUM_W-1:0]    up_sum;

    // Input resolution: mode 3 behaves as single, out-of-range channel maps to 0
    always_comb begin
        mode_norm = (mode == 2'd3) ? M_SINGLE : mode_t'(mode);
        ch_res    = ({1'b0, ch_sel} < CH_LIMIT) ? ch_sel : 4'd0;
    end

    // Next-state, envelope and output logic
    always_comb begin
        period_tick = (pwm_cnt == PERIOD_M1);
        up_sum      = {1'b0, duty} + STEP_X;
        lit         = (pwm_cnt < duty);

        state_d   = state;
        mode_d    = cur_mode;
        pwm_cnt_d = period_tick ? '0 : pwm_cnt + CNT_W'(1);
        duty_d    = duty;
        hold_d    = hold_cnt;
        ch_d      = active_ch;
        done_d    = 1'b0;
        led_d     = '0;

        unique case (state)
            S_IDLE: begin
                pwm_cnt_d = '0;
                duty_d    = '0;
                hold_d    = '0;
                if (en) begin
                    state_d = S_UP;
                    mode_d  = mode_norm;
                    ch_d    = (mode_norm == M_ALL) ? 4'd0 : ch_res;
                end
            end
            S_UP: begin
                if (period_tick) begin
                    if (up_sum >= PERIOD_X) begin
                        duty_d  = PERIOD_V;
                        hold_d  = '0;
                        state_d = S_HOLD_ON;
                    end else begin
                        duty_d = up_sum[CNT_W-1:0];
                    end
                end
            end
            S_HOLD_ON: begin
                if (period_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = S_DOWN;
                    end else begin
                        hold_d = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            S_DOWN: begin
                if (period_tick) begin
                    if (duty <= STEP_V) begin
                        duty_d  = '0;
                        hold_d  = '0;
                        state_d = S_HOLD_OFF;
                    end else begin
                        duty_d = duty - STEP_V;
                    end
                end
            end
            S_HOLD_OFF: begin
                if (period_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_d  = '0;
                        done_d  = 1'b1;
                        mode_d  = mode_norm;
                        state_d = en ? S_UP : S_IDLE;
                        // A mode change restarts channel selection for the new mode
                        if (mode_norm != cur_mode) begin
                            ch_d = (mode_norm == M_SINGLE) ? ch_res : 4'd0;
                        end else begin
                            unique case (cur_mode)
                                M_CHASE:  ch_d = (active_ch == CH_LAST) ? 4'd0 : active_ch + 4'd1;
                                M_SINGLE: ch_d = ch_res;
                                default:  ch_d = 4'd0;
                            endcase
                        end
                    end else begin
                        hold_d = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state != S_IDLE && lit) begin
            if (cur_mode == M_ALL) begin
                led_d = '1;
            end else begin
                led_d = NUM_CH'(1) << active_ch;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_mode   <= M_SINGLE;
            pwm_cnt    <= '0;
            duty       <= '0;
            hold_cnt   <= '0;
            active_ch  <= 4'd0;
            led_out    <= '0;
            busy       <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_d;
            cur_mode   <= mode_d;
            pwm_cnt    <= pwm_cnt_d;
            duty       <= duty_d;
            hold_cnt   <= hold_d;
            active_ch  <= ch_d;
            led_out    <= led_d;
            busy       <= busy_d;
            cycle_done <= done_d;
        end
    end

endmodule
